// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed from latched operands and committed when the latency counter expires.
module mdu_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
    logic               w_launch, w_commit, w_wr;
    logic [2*WIDTH-1:0] w_prod_s, w_prod_u, w_prod;
    logic               w_sgn;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_den, w_uq, w_ur, w_q, w_r;
    logic [WIDTH-1:0]   w_res_hi, w_res_lo;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_launch) begin
                r_op <= md_op;
                r_a  <= in1;
                r_b  <= in2;
            end
            if (w_commit) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (w_wr) begin
                if (hilo_sel) r_hi <= wdata;
                else          r_lo <= wdata;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_launch    = 1'b0;
        w_commit    = 1'b0;
        w_wr        = 1'b0;
        if (r_state == S_IDLE) begin
            w_launch = start;
            w_wr     = hilo_we & ~start;
            if (start) begin
                w_state_nxt = S_BUSY;
                w_cnt_nxt   = md_op[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
            end
        end else begin
            w_cnt_nxt = r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
            end
        end
    end

    // Sign-extending to 2*WIDTH makes the modular product equal the signed product.
    assign w_prod_s = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
    assign w_prod   = r_op[0] ? w_prod_u : w_prod_s;

    // Signed divide via magnitudes; most-negative / -1 falls out as most-negative, 0.
    always_comb begin
        w_sgn   = ~r_op[0];
        w_mag_a = (w_sgn && r_a[WIDTH-1]) ? -r_a : r_a;
        w_mag_b = (w_sgn && r_b[WIDTH-1]) ? -r_b : r_b;
        w_den   = (r_b == '0) ? WIDTH'(1) : w_mag_b;
        w_uq    = w_mag_a / w_den;
        w_ur    = w_mag_a % w_den;
        w_q     = (w_sgn && (r_a[WIDTH-1] ^ r_b[WIDTH-1])) ? -w_uq : w_uq;
        w_r     = (w_sgn && r_a[WIDTH-1]) ? -w_ur : w_ur;
    end

    assign w_res_lo = !r_op[1] ? w_prod[WIDTH-1:0] : (r_b == '0) ? '1 : w_q;
    assign w_res_hi = !r_op[1] ? w_prod[2*WIDTH-1:WIDTH] : (r_b == '0) ? r_a : w_r;

    assign busy = (r_state == S_BUSY);
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: table vectors, hand-written corner sequences and random ops against a 64-bit arithmetic model.
module tb_mdu_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  md_op = '0;
    logic [31:0] in1 = '0, in2 = '0, wdata = '0;
    logic        hilo_we = 1'b0, hilo_sel = 1'b0;
    logic        busy;
    logic [31:0] hi, lo;

    int total = 0;
    int bad = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;
    vec_t tv[6];

    mdu_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op),
        .in1(in1), .in2(in2), .hilo_we(hilo_we), .hilo_sel(hilo_sel),
        .wdata(wdata), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        logic [63:0] r;
        case (op)
            2'd0: r = 64'(sa * sb);
            2'd1: r = {32'b0, a} * {32'b0, b};
            2'd2: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            default: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit intf, input bit we_too);
        int n = 0;
        int want = op[1] ? 10 : 5;
        start = 1'b1;
        md_op = op;
        in1 = a;
        in2 = b;
        if (we_too) begin
            hilo_we = 1'b1;
            hilo_sel = 1'($urandom_range(0, 1));
            wdata = $urandom;
        end
        tick();
        start = 1'b0;
        hilo_we = 1'b0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (intf) begin
                in1 = $urandom;
                in2 = $urandom;
                md_op = 2'($urandom);
                start = (n == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                hilo_we = 1'b1;
                hilo_sel = 1'($urandom_range(0, 1));
                wdata = $urandom;
            end
            tick();
        end
        chk({nm, "_busy_len"}, 32'(n), 32'(want));
        chk({nm, "_hi"}, hi, exp[63:32]);
        chk({nm, "_lo"}, lo, exp[31:0]);
        start = 1'b0;
        hilo_we = 1'b0;
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    initial begin
        tv[0] = '{2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tv[1] = '{2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
        tv[2] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tv[3] = '{2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC};
        tv[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        tv[5] = '{2'd3, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};

        #3;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++)
            run_op($sformatf("tv%0d", i), tv[i].op, tv[i].a, tv[i].b, {tv[i].hi, tv[i].lo}, i[0], i == 2);

        hilo_we = 1'b1;
        hilo_sel = 1'b1;
        wdata = 32'hA5A5_A5A5;
        tick();
        hilo_we = 1'b0;
        chk("mthi_hi", hi, 32'hA5A5_A5A5);
        chk("mthi_lo", lo, m_lo);
        m_hi = 32'hA5A5_A5A5;

        run_op("mtlo_busy", 2'd1, 32'd3, 32'd4, 64'd12, 1'b1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [1:0] op = 2'($urandom);
            logic [31:0] a = $urandom;
            logic [31:0] b = (i % 6 == 0) ? 32'd0 : (i % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            if (i % 7 == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            run_op($sformatf("rnd%0d", i), op, a, b, ref_md(op, a, b), i[0], i % 5 == 0);
        end

        start = 1'b1;
        md_op = 2'd0;
        in1 = 32'd7;
        in2 = 32'd9;
        tick();
        start = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (12) tick();
        chk("postrst_busy", {31'b0, busy}, 32'd0);
        chk("postrst_hi", hi, 32'd0);
        chk("postrst_lo", lo, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
